// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM states and default widths.
package axi4_lite_pkg;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_ERRCNT_W = 16;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_e;

  // SLVERR and DECERR both carry resp[1] = 1.
  function automatic logic is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi4_lite_master_cmd_if.sv
// AXI4-Lite bus bundle between the command master and a 32-bit register slave.
interface axi4_lite_master_cmd_if
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [2:0]          M_AXI_AWPROT;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic [2:0]          M_AXI_ARPROT;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );

endinterface

// File: rtl/axi4_lite_master_cmd.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction, one response out.
// Keeps a saturating count of SLVERR/DECERR responses.
module axi4_lite_master_cmd
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ERRCNT_W = DEF_ERRCNT_W
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [2:0]          cmd_prot,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [ERRCNT_W-1:0] err_count,
  axi4_lite_master_cmd_if.master m_axi
);

  state_e state, state_d;
  logic   aw_done, w_done, aw_done_d, w_done_d;
  logic   cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
  logic   resp_take;
  logic [1:0] resp_in;

  assign cmd_hs = cmd_valid & cmd_ready;
  assign aw_hs  = m_axi.M_AXI_AWVALID & m_axi.M_AXI_AWREADY;
  assign w_hs   = m_axi.M_AXI_WVALID  & m_axi.M_AXI_WREADY;
  assign b_hs   = m_axi.M_AXI_BREADY  & m_axi.M_AXI_BVALID;
  assign ar_hs  = m_axi.M_AXI_ARVALID & m_axi.M_AXI_ARREADY;
  assign r_hs   = m_axi.M_AXI_RREADY  & m_axi.M_AXI_RVALID;
  assign rsp_hs = rsp_valid & rsp_ready;

  always_comb begin
    state_d   = state;
    aw_done_d = aw_done;
    w_done_d  = w_done;
    unique case (state)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (cmd_hs) state_d = cmd_write ? WR_ADDR_DATA : RD_ADDR;
      end
      WR_ADDR_DATA: begin
        aw_done_d = aw_done | aw_hs;
        w_done_d  = w_done  | w_hs;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: if (b_hs)   state_d = RESP;
      RD_ADDR: if (ar_hs)  state_d = RD_DATA;
      RD_DATA: if (r_hs)   state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_d;
      aw_done <= aw_done_d;
      w_done  <= w_done_d;
    end
  end

  // Handshake outputs are registered from the next-state so each one lines up with its state.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cmd_ready           <= 1'b1;
      rsp_valid           <= 1'b0;
      m_axi.M_AXI_AWVALID <= 1'b0;
      m_axi.M_AXI_WVALID  <= 1'b0;
      m_axi.M_AXI_BREADY  <= 1'b0;
      m_axi.M_AXI_ARVALID <= 1'b0;
      m_axi.M_AXI_RREADY  <= 1'b0;
    end else begin
      cmd_ready           <= (state_d == IDLE);
      rsp_valid           <= (state_d == RESP);
      m_axi.M_AXI_AWVALID <= (state_d == WR_ADDR_DATA) && !aw_done_d;
      m_axi.M_AXI_WVALID  <= (state_d == WR_ADDR_DATA) && !w_done_d;
      m_axi.M_AXI_BREADY  <= (state_d == WR_RESP);
      m_axi.M_AXI_ARVALID <= (state_d == RD_ADDR);
      m_axi.M_AXI_RREADY  <= (state_d == RD_DATA);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axi.M_AXI_AWADDR <= '0;
      m_axi.M_AXI_AWPROT <= '0;
      m_axi.M_AXI_WDATA  <= '0;
      m_axi.M_AXI_WSTRB  <= '0;
      m_axi.M_AXI_ARADDR <= '0;
      m_axi.M_AXI_ARPROT <= '0;
    end else if (cmd_hs) begin
      if (cmd_write) begin
        m_axi.M_AXI_AWADDR <= cmd_addr;
        m_axi.M_AXI_AWPROT <= cmd_prot;
        m_axi.M_AXI_WDATA  <= cmd_wdata;
        m_axi.M_AXI_WSTRB  <= cmd_wstrb;
      end else begin
        m_axi.M_AXI_ARADDR <= cmd_addr;
        m_axi.M_AXI_ARPROT <= cmd_prot;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else if (b_hs) begin
      rsp_write <= 1'b1;
      rsp_rdata <= '0;
      rsp_resp  <= m_axi.M_AXI_BRESP;
    end else if (r_hs) begin
      rsp_write <= 1'b0;
      rsp_rdata <= m_axi.M_AXI_RDATA;
      rsp_resp  <= m_axi.M_AXI_RRESP;
    end
  end

  assign resp_take = b_hs | r_hs;
  assign resp_in   = b_hs ? m_axi.M_AXI_BRESP : m_axi.M_AXI_RRESP;

  always_ff @(posedge aclk) begin
    if (areset) begin
      err_count <= '0;
    end else if (resp_take && is_err(resp_in) && (err_count != '1)) begin
      err_count <= err_count + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_cmd.sv
// Directed scoreboard bench for axi4_lite_master_cmd with a behavioural AXI4-Lite slave.
module tb_axi4_lite_master_cmd;
  import axi4_lite_pkg::*;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid, cmd_write, rsp_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_prot;
  logic [3:0]  cmd_wstrb;
  logic        cmd_ready, rsp_valid, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] err_count;
  logic        cmd_ready2, rsp_valid2, rsp_write2;
  logic [31:0] rsp_rdata2;
  logic [1:0]  rsp_resp2;
  logic [1:0]  err_count2;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 aclk = ~aclk;

  axi4_lite_master_cmd_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  axi4_lite_master_cmd_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  // Second DUT (2-bit error counter) sees the same slave responses as the first.
  assign bus2.M_AXI_AWREADY = bus.M_AXI_AWREADY;
  assign bus2.M_AXI_WREADY  = bus.M_AXI_WREADY;
  assign bus2.M_AXI_BRESP   = bus.M_AXI_BRESP;
  assign bus2.M_AXI_BVALID  = bus.M_AXI_BVALID;
  assign bus2.M_AXI_ARREADY = bus.M_AXI_ARREADY;
  assign bus2.M_AXI_RDATA   = bus.M_AXI_RDATA;
  assign bus2.M_AXI_RRESP   = bus.M_AXI_RRESP;
  assign bus2.M_AXI_RVALID  = bus.M_AXI_RVALID;

  axi4_lite_master_cmd #(.ADDR_W(32), .DATA_W(32), .ERRCNT_W(16)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_prot(cmd_prot), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
    .m_axi(bus)
  );

  axi4_lite_master_cmd #(.ADDR_W(32), .DATA_W(32), .ERRCNT_W(2)) dut2 (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_prot(cmd_prot), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_write(rsp_write2),
    .rsp_rdata(rsp_rdata2), .rsp_resp(rsp_resp2), .err_count(err_count2),
    .m_axi(bus2)
  );

  // Slave configuration and state
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic        b_early = 1'b0;
  logic [1:0]  cfg_bresp = OKAY, cfg_rresp = OKAY;
  logic [31:0] cfg_rdata = '0;
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic        aw_done, w_done, ar_done, ar_pend, b_pend, r_pend;
  int          b_count = 0, r_count = 0;

  task automatic slave_clear();
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    aw_done = 0; w_done = 0; ar_done = 0; ar_pend = 0; b_pend = 0; r_pend = 0;
    bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = 0;
    bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0; bus.M_AXI_RDATA = 0; bus.M_AXI_RRESP = 0;
  endtask

  initial begin
    slave_clear();
    forever begin
      @(posedge aclk);
      if (areset) slave_clear();
      @(negedge aclk);
      if (b_pend) begin
        bus.M_AXI_BVALID = 0; aw_done = 0; w_done = 0; b_wait = 0; b_pend = 0; b_count++;
      end
      if (r_pend) begin
        bus.M_AXI_RVALID = 0; ar_done = 0; r_wait = 0; r_pend = 0; r_count++;
      end
      if (ar_pend) begin ar_done = 1; ar_pend = 0; end
      bus.M_AXI_AWREADY = 0;
      if (bus.M_AXI_AWVALID) begin
        if (aw_wait >= aw_dly) begin bus.M_AXI_AWREADY = 1; aw_wait = 0; aw_done = 1; end
        else aw_wait++;
      end
      bus.M_AXI_WREADY = 0;
      if (bus.M_AXI_WVALID) begin
        if (w_wait >= w_dly) begin bus.M_AXI_WREADY = 1; w_wait = 0; w_done = 1; end
        else w_wait++;
      end
      bus.M_AXI_ARREADY = 0;
      if (bus.M_AXI_ARVALID) begin
        if (ar_wait >= ar_dly) begin bus.M_AXI_ARREADY = 1; ar_wait = 0; ar_pend = 1; end
        else ar_wait++;
      end
      if (!bus.M_AXI_BVALID) begin
        if (b_early && bus.M_AXI_AWVALID) bus.M_AXI_BVALID = 1;
        else if (aw_done && w_done) begin
          if (b_wait >= b_dly) bus.M_AXI_BVALID = 1;
          else b_wait++;
        end
      end
      bus.M_AXI_BRESP = cfg_bresp;
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) b_pend = 1;
      if (!bus.M_AXI_RVALID && ar_done) begin
        if (r_wait >= r_dly) bus.M_AXI_RVALID = 1;
        else r_wait++;
      end
      bus.M_AXI_RDATA = bus.M_AXI_RVALID ? cfg_rdata : 32'h0;
      bus.M_AXI_RRESP = cfg_rresp;
      if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) r_pend = 1;
    end
  end

  // Scoreboard
  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t expq[$];
  logic [15:0] err_model = '0;
  logic [1:0]  err_model2 = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] exp_resp, input logic [31:0] exp_rdata);
    exp_t e;
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin @(negedge aclk); n++; end
    check("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    cmd_wstrb = 4'hF; cmd_prot = 3'b010;
    e.wr = wr; e.rdata = wr ? 32'h0 : exp_rdata; e.resp = exp_resp;
    expq.push_back(e);
    @(negedge aclk);
    cmd_valid = 0;
  endtask

  task automatic get_rsp(input int hold);
    exp_t e;
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin @(negedge aclk); n++; end
    check("rsp_valid_wait", 64'(rsp_valid), 64'(1));
    if (expq.size() == 0) begin
      check("scoreboard_empty", 64'(expq.size()), 64'(1));
      return;
    end
    e = expq.pop_front();
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'(1));
      check("hold_rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
      check("hold_rsp_resp", 64'(rsp_resp), 64'(e.resp));
      check("hold_cmd_ready", 64'(cmd_ready), 64'(0));
    end
    rsp_ready = 1;
    check("rsp_write", 64'(rsp_write), 64'(e.wr));
    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
    check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
    check("rsp_resp_dut2", 64'(rsp_resp2), 64'(e.resp));
    check("rsp_valid_dut2", 64'(rsp_valid2), 64'(1));
    if (e.resp[1]) begin
      if (err_model != 16'hFFFF) err_model++;
      if (err_model2 != 2'b11) err_model2++;
    end
    @(negedge aclk);
    rsp_ready = 0;
    check("post_rsp_valid", 64'(rsp_valid), 64'(0));
    check("post_cmd_ready", 64'(cmd_ready), 64'(1));
    check("post_cmd_ready_dut2", 64'(cmd_ready2), 64'(1));
    check("err_count", 64'(err_count), 64'(err_model));
    check("err_count_dut2", 64'(err_count2), 64'(err_model2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int n;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_prot = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 0;
    repeat (3) @(negedge aclk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_write", 64'(rsp_write), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_rsp_resp", 64'(rsp_resp), 64'(0));
    check("rst_err_count", 64'(err_count), 64'(0));
    check("rst_valids", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}), 64'(0));
    check("rst_readys", 64'({bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 64'(0));
    check("rst_payload", 64'(bus.M_AXI_AWADDR | bus.M_AXI_WDATA | bus.M_AXI_ARADDR), 64'(0));
    areset = 0;
    @(negedge aclk);

    // Minimum-latency write
    send_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, OKAY, 32'h0);
    check("w1_awvalid_c1", 64'(bus.M_AXI_AWVALID), 64'(1));
    check("w1_wvalid_c1", 64'(bus.M_AXI_WVALID), 64'(1));
    check("w1_awaddr", 64'(bus.M_AXI_AWADDR), 64'h10);
    check("w1_awprot", 64'(bus.M_AXI_AWPROT), 64'(3'b010));
    check("w1_wdata", 64'(bus.M_AXI_WDATA), 64'hDEAD_BEEF);
    check("w1_wstrb", 64'(bus.M_AXI_WSTRB), 64'hF);
    check("w1_cmd_ready_c1", 64'(cmd_ready), 64'(0));
    @(negedge aclk);
    check("w1_bready_c2", 64'(bus.M_AXI_BREADY), 64'(1));
    check("w1_awvalid_c2", 64'(bus.M_AXI_AWVALID), 64'(0));
    check("w1_rsp_valid_c2", 64'(rsp_valid), 64'(0));
    @(negedge aclk);
    check("w1_rsp_valid_c3", 64'(rsp_valid), 64'(1));
    get_rsp(0);

    // AWREADY delayed 3 cycles, BVALID offered early
    aw_dly = 3; b_early = 1;
    b0 = b_count;
    send_cmd(1'b1, 32'h0000_0020, 32'h0000_55AA, OKAY, 32'h0);
    check("w2_awvalid_c1", 64'(bus.M_AXI_AWVALID), 64'(1));
    check("w2_wvalid_c1", 64'(bus.M_AXI_WVALID), 64'(1));
    for (int c = 2; c <= 4; c++) begin
      @(negedge aclk);
      check("w2_wvalid_dropped", 64'(bus.M_AXI_WVALID), 64'(0));
      check("w2_awvalid_held", 64'(bus.M_AXI_AWVALID), 64'(1));
      check("w2_awaddr_stable", 64'(bus.M_AXI_AWADDR), 64'h20);
      check("w2_bready_low", 64'(bus.M_AXI_BREADY), 64'(0));
    end
    @(negedge aclk);
    check("w2_bready_c5", 64'(bus.M_AXI_BREADY), 64'(1));
    check("w2_awvalid_c5", 64'(bus.M_AXI_AWVALID), 64'(0));
    get_rsp(0);
    check("w2_one_b", 64'(b_count - b0), 64'(1));
    check("w2_no_extra_rsp", 64'(rsp_valid), 64'(0));
    aw_dly = 0; b_early = 0;

    // Read with RVALID delayed
    r_dly = 2; cfg_rdata = 32'h1234_5678; cfg_rresp = OKAY;
    send_cmd(1'b0, 32'h0000_0004, 32'h0, OKAY, 32'h1234_5678);
    check("r1_arvalid_c1", 64'(bus.M_AXI_ARVALID), 64'(1));
    check("r1_araddr", 64'(bus.M_AXI_ARADDR), 64'h4);
    check("r1_awvalid_c1", 64'(bus.M_AXI_AWVALID), 64'(0));
    @(negedge aclk);
    check("r1_rready_c2", 64'(bus.M_AXI_RREADY), 64'(1));
    get_rsp(0);

    // DECERR read, response held 4 cycles
    r_dly = 0; cfg_rdata = 32'hCAFE_F00D; cfg_rresp = DECERR;
    send_cmd(1'b0, 32'h0000_0008, 32'h0, DECERR, 32'hCAFE_F00D);
    get_rsp(4);
    cfg_rresp = OKAY;

    // Reset while waiting for B
    b_dly = 5;
    send_cmd(1'b1, 32'h0000_0030, 32'h0BAD_F00D, OKAY, 32'h0);
    n = 0;
    while (bus.M_AXI_BREADY !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    check("rst_mid_bready_seen", 64'(bus.M_AXI_BREADY), 64'(1));
    areset = 1;
    @(negedge aclk);
    check("rstm_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rstm_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rstm_err_count", 64'(err_count), 64'(0));
    check("rstm_err_count_dut2", 64'(err_count2), 64'(0));
    check("rstm_valids", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}), 64'(0));
    check("rstm_readys", 64'({bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 64'(0));
    areset = 0;
    expq.delete();
    err_model = '0; err_model2 = '0;
    b_dly = 0;
    @(negedge aclk);

    // Five SLVERR writes: 2-bit counter saturates at 3
    cfg_bresp = SLVERR;
    for (int k = 0; k < 5; k++) begin
      send_cmd(1'b1, 32'h0000_0040 + 32'(k * 4), 32'(k), SLVERR, 32'h0);
      get_rsp(0);
    end
    check("sat_err_count", 64'(err_count), 64'(5));
    check("sat_err_count_dut2", 64'(err_count2), 64'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
